branch_resolve: RTL and testbench

- Downstream of the tournament branch predictor in the fetch/execute path.
- Queues every predicted branch issued by fetch, then checks the head entry against the actual outcome from execute, in order.
- On a mismatch it flushes, redirects the PC and empties the queue.
- Sends a registered training update back to the predictor and keeps saturating accuracy counters.

---
 rtl/branch_resolve.sv | 119 +++++++++++
 tb/tb_branch_resolve.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - in-order branch outcome check, flush/redirect and predictor training
module branch_resolve #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pred_valid,
   input  logic             pred_taken,
   input  logic [31:0]      pred_pc,
   input  logic [31:0]      pred_target,
   output logic             pred_ready,
   input  logic             res_valid,
   input  logic             res_taken,
   input  logic [31:0]      res_target,
   output logic             flush,
   output logic [31:0]      redirect_pc,
   output logic             upd_valid,
   output logic [31:0]      upd_pc,
   output logic             upd_taken,
   output logic             empty,
   output logic             underflow,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [31:0]   q_pc     [DEPTH];
   logic          q_taken  [DEPTH];
   logic [31:0]   q_target [DEPTH];

   logic [PW-1:0] head, tail, head_n, tail_n;
   logic [PW:0]   count, count_n;

   logic          full, has_entry;
   logic          do_push, do_res, mispredict;
   logic [31:0]   correct_pc;

   assign full       = (count == FULL_CNT);
   assign has_entry  = (count != '0);
   assign empty      = ~has_entry;
   assign pred_ready = ~full;

   // A full queue still accepts a push when a resolve frees the head slot in the same cycle
   assign do_res     = res_valid & has_entry;
   assign do_push    = pred_valid & (~full | do_res);

   assign mispredict = (res_taken != q_taken[head]) |
                       (res_taken & (res_target != q_target[head]));
   assign correct_pc = res_taken ? res_target : (q_pc[head] + 32'd4);

   // Pointer/count update; a mispredict drops every queued entry and any same-cycle push
   always_comb begin
      head_n  = head;
      tail_n  = tail;
      count_n = count;
      if (do_res && mispredict) begin
         head_n  = '0;
         tail_n  = '0;
         count_n = '0;
      end else begin
         if (do_push) tail_n = tail + 1'b1;
         if (do_res)  head_n = head + 1'b1;
         if (do_push && !do_res)
            count_n = count + 1'b1;
         else if (do_res && !do_push)
            count_n = count - 1'b1;
      end
   end

   // Entry storage; holds no control state so it needs no reset
   always_ff @(posedge clk) begin
      if (do_push) begin
         q_pc[tail]     <= pred_pc;
         q_taken[tail]  <= pred_taken;
         q_target[tail] <= pred_target;
      end
   end

   // Queue control, registered resolve outputs, error flag and saturating counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         flush       <= 1'b0;
         redirect_pc <= '0;
         upd_valid   <= 1'b0;
         upd_pc      <= '0;
         upd_taken   <= 1'b0;
         underflow   <= 1'b0;
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         head      <= head_n;
         tail      <= tail_n;
         count     <= count_n;
         upd_valid <= do_res;
         flush     <= do_res & mispredict;
         if (do_res) begin
            upd_pc    <= q_pc[head];
            upd_taken <= res_taken;
            if (branch_cnt != CNT_MAX)
               branch_cnt <= branch_cnt + 1'b1;
            if (mispredict) begin
               redirect_pc <= correct_pc;
               if (mispred_cnt != CNT_MAX)
                  mispred_cnt <= mispred_cnt + 1'b1;
            end
         end
         if (res_valid && !has_entry)
            underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pred_valid, pred_taken, res_valid, res_taken;
   logic [31:0] pred_pc, pred_target, res_target;
   logic        pred_ready, flush, upd_valid, upd_taken, empty, underflow;
   logic [31:0] redirect_pc, upd_pc;
   logic [15:0] branch_cnt, mispred_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic        fl;
      logic [31:0] rd;
   } exp_t;

   exp_t sb[$];

   branch_resolve #(.DEPTH(4), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc),
      .pred_target(pred_target), .pred_ready(pred_ready),
      .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
      .flush(flush), .redirect_pc(redirect_pc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .empty(empty), .underflow(underflow),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, advance past the edge, then return inputs to idle
   task automatic cyc(input logic pv, input logic pt, input logic [31:0] ppc, input logic [31:0] ptg,
                      input logic rv, input logic rt, input logic [31:0] rtg);
      pred_valid = pv; pred_taken = pt; pred_pc = ppc; pred_target = ptg;
      res_valid  = rv; res_taken  = rt; res_target = rtg;
      @(posedge clk); #1;
      pred_valid = 1'b0;
      res_valid  = 1'b0;
   endtask

   task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tg);
      cyc(1'b1, t, pc, tg, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic res(input logic t, input logic [31:0] tg);
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, t, tg);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic expect_upd(input logic [31:0] pc, input logic t, input logic fl, input logic [31:0] rd);
      exp_t e;
      e.pc = pc; e.taken = t; e.fl = fl; e.rd = rd;
      sb.push_back(e);
   endtask

   // Monitor: every training pulse is matched against the oldest expected resolve
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (upd_valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_upd: got upd_pc %h expected no update", upd_pc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("upd_pc", upd_pc, e.pc);
               chk("upd_taken", {31'b0, upd_taken}, {31'b0, e.taken});
               chk("flush", {31'b0, flush}, {31'b0, e.fl});
               if (e.fl) chk("redirect_pc", redirect_pc, e.rd);
            end
         end else if (flush) begin
            checks++;
            errors++;
            $display("FAIL flush_without_upd: got flush 1 expected 0");
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      pred_valid = 1'b0; pred_taken = 1'b0; pred_pc = '0; pred_target = '0;
      res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
      #2;
      chk("rst_empty", {31'b0, empty}, 32'd1);
      chk("rst_pred_ready", {31'b0, pred_ready}, 32'd1);
      chk("rst_flush", {31'b0, flush}, 32'd0);
      chk("rst_upd_valid", {31'b0, upd_valid}, 32'd0);
      chk("rst_underflow", {31'b0, underflow}, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'h0);
      chk("rst_branch_cnt", {16'b0, branch_cnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();

      // Fill the queue, then a fifth push must be dropped
      push(32'h100, 1'b1, 32'h200);
      push(32'h104, 1'b0, 32'h0);
      push(32'h108, 1'b1, 32'h300);
      push(32'h10C, 1'b0, 32'h0);
      chk("full_pred_ready", {31'b0, pred_ready}, 32'd0);
      push(32'h110, 1'b1, 32'h500);
      chk("full_still", {31'b0, pred_ready}, 32'd0);

      // Resolve all four as predicted
      expect_upd(32'h100, 1'b1, 1'b0, 32'h0); res(1'b1, 32'h200);
      expect_upd(32'h104, 1'b0, 1'b0, 32'h0); res(1'b0, 32'h0);
      expect_upd(32'h108, 1'b1, 1'b0, 32'h0); res(1'b1, 32'h300);
      expect_upd(32'h10C, 1'b0, 1'b0, 32'h0); res(1'b0, 32'h0);
      idle();
      chk("t2_empty", {31'b0, empty}, 32'd1);
      chk("t2_branch_cnt", {16'b0, branch_cnt}, 32'd4);
      chk("t2_mispred_cnt", {16'b0, mispred_cnt}, 32'd0);

      // Direction mispredict, then target mispredict
      push(32'h100, 1'b1, 32'h200);
      expect_upd(32'h100, 1'b0, 1'b1, 32'h104); res(1'b0, 32'h0);
      idle();
      chk("t3_mispred_cnt", {16'b0, mispred_cnt}, 32'd1);
      push(32'h100, 1'b1, 32'h200);
      expect_upd(32'h100, 1'b1, 1'b1, 32'h240); res(1'b1, 32'h240);
      idle();
      idle();
      chk("t3_redirect_hold", redirect_pc, 32'h240);
      chk("t3_mispred_cnt2", {16'b0, mispred_cnt}, 32'd2);

      // Mispredict with three queued and a simultaneous push
      push(32'h200, 1'b0, 32'h0);
      push(32'h204, 1'b1, 32'h400);
      push(32'h208, 1'b0, 32'h0);
      expect_upd(32'h200, 1'b1, 1'b1, 32'h999);
      cyc(1'b1, 1'b0, 32'h20C, 32'h0, 1'b1, 1'b1, 32'h999);
      chk("t4_empty", {31'b0, empty}, 32'd1);
      chk("t4_pred_ready", {31'b0, pred_ready}, 32'd1);
      push(32'h300, 1'b0, 32'h0);
      expect_upd(32'h300, 1'b0, 1'b0, 32'h0); res(1'b0, 32'h0);
      idle();
      chk("t4_empty2", {31'b0, empty}, 32'd1);

      // Full queue: resolve and push together, tail wraps
      push(32'h400, 1'b0, 32'h0);
      push(32'h404, 1'b0, 32'h0);
      push(32'h408, 1'b0, 32'h0);
      push(32'h40C, 1'b0, 32'h0);
      expect_upd(32'h400, 1'b0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 32'h410, 32'h0, 1'b1, 1'b0, 32'h0);
      chk("t5_still_full", {31'b0, pred_ready}, 32'd0);
      expect_upd(32'h404, 1'b0, 1'b0, 32'h0); res(1'b0, 32'h0);
      expect_upd(32'h408, 1'b0, 1'b0, 32'h0); res(1'b0, 32'h0);
      expect_upd(32'h40C, 1'b0, 1'b0, 32'h0); res(1'b0, 32'h0);
      expect_upd(32'h410, 1'b0, 1'b0, 32'h0); res(1'b0, 32'h0);
      idle();
      chk("t5_empty", {31'b0, empty}, 32'd1);
      chk("t5_branch_cnt", {16'b0, branch_cnt}, 32'd13);
      chk("t5_mispred_cnt", {16'b0, mispred_cnt}, 32'd3);

      // Underflow, then asynchronous reset mid-cycle with entries queued
      res(1'b1, 32'h123);
      idle();
      chk("t6_underflow", {31'b0, underflow}, 32'd1);
      chk("t6_branch_cnt", {16'b0, branch_cnt}, 32'd13);
      push(32'h500, 1'b0, 32'h0);
      push(32'h504, 1'b0, 32'h0);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_empty", {31'b0, empty}, 32'd1);
      chk("arst_pred_ready", {31'b0, pred_ready}, 32'd1);
      chk("arst_underflow", {31'b0, underflow}, 32'd0);
      chk("arst_redirect_pc", redirect_pc, 32'h0);
      chk("arst_upd_pc", upd_pc, 32'h0);
      chk("arst_branch_cnt", {16'b0, branch_cnt}, 32'd0);
      chk("arst_mispred_cnt", {16'b0, mispred_cnt}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();
      push(32'h600, 1'b0, 32'h0);
      expect_upd(32'h600, 1'b0, 1'b0, 32'h0); res(1'b0, 32'h0);
      idle();
      idle();
      chk("sb_drained", sb.size(), 32'd0);
      chk("final_branch_cnt", {16'b0, branch_cnt}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
